mxint8_dequant_stream: RTL and testbench

MXINT8_DEQUANT_STREAM -- requirements
Module: mxint8_dequant_stream

---
 rtl/mxint8_dequant_stream.sv | 192 +++++++++++++++++++
 tb/tb_mxint8_dequant_stream.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mxint8_dequant_stream.sv
// MXINT8 block dequantiser: captures 32 int8 elements with a shared E8M0 scale and streams them out as binary32 words.
// Define MXINT8_DEQUANT_PREFETCH_EN to add a second block register so the next block can be accepted while one streams.
`ifndef MXINT8_ELEMENT_WIDTH
`define MXINT8_ELEMENT_WIDTH 8
`endif
`ifndef SCALE_WIDTH
`define SCALE_WIDTH 8
`endif
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 32
`endif
`ifndef FLOAT32_WIDTH
`define FLOAT32_WIDTH 32
`endif

module mxint8_dequant_stream (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [`SCALE_WIDTH-1:0]                       in_scale,
  input  logic [`MXINT8_ELEMENT_WIDTH*`BLOCK_SIZE-1:0]  in_elements,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [`FLOAT32_WIDTH-1:0]                     out_data,
  output logic [4:0]                                    out_index,
  output logic                                          out_last
);

  localparam int BLK_W = `MXINT8_ELEMENT_WIDTH * `BLOCK_SIZE;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  // Exact conversion of elem * 2^(scale-133); magnitudes never exceed 8 significant bits, so no rounding.
  function automatic logic [31:0] mx_decode(input logic [7:0] scale, input logic [7:0] elem);
    logic              sgn;
    logic [8:0]        mag;
    logic [2:0]        lead;
    logic signed [9:0] bexp;
    logic [22:0]       frac_n;
    logic [22:0]       frac_s;
    logic [31:0]       word;
    sgn  = elem[7];
    mag  = sgn ? (9'd256 - {1'b0, elem}) : {1'b0, elem};
    lead = 3'd0;
    for (int i = 0; i < 8; i++) begin
      lead = mag[i] ? 3'(i) : lead;
    end
    bexp   = $signed({2'b00, scale}) + $signed({7'd0, lead}) - 10'sd6;
    frac_n = {14'd0, mag} << (5'd23 - {2'b00, lead});
    frac_s = {14'd0, mag} << ({1'b0, scale} + 9'd16);
    if (scale == 8'hFF) begin
      word = 32'h7FC0_0000;
    end else if (mag == 9'd0) begin
      word = 32'h0000_0000;
    end else if (bexp >= 10'sd255) begin
      word = {sgn, 8'hFF, 23'd0};
    end else if (bexp >= 10'sd1) begin
      word = {sgn, bexp[7:0], frac_n};
    end else begin
      word = {sgn, 8'h00, frac_s};
    end
    return word;
  endfunction

  state_t           state_q;
  logic [BLK_W-1:0] blk_q;
  logic [7:0]       scale_q;
  logic             out_valid_q;
  logic [31:0]      out_data_q;
  logic [4:0]       out_index_q;
  logic             out_last_q;

  logic             accept_s;
  logic             out_hs_s;
  logic             last_hs_s;
  logic [4:0]       next_idx_d;
  logic [31:0]      next_word_d;
  logic [31:0]      in_word_d;

`ifdef MXINT8_DEQUANT_PREFETCH_EN
  logic [BLK_W-1:0] buf_q;
  logic [7:0]       buf_scale_q;
  logic             buf_full_q;
  logic [31:0]      buf_word_d;

  assign in_ready = rst_n & ~buf_full_q;
`else
  assign in_ready = rst_n & (state_q == S_IDLE);
`endif

  assign accept_s  = in_valid & in_ready;
  assign out_hs_s  = out_valid_q & out_ready;
  assign last_hs_s = out_hs_s & out_last_q;

  // Decode the word that will be presented next, from whichever source feeds it.
  always_comb begin
    next_idx_d  = out_index_q + 5'd1;
    next_word_d = mx_decode(scale_q, blk_q[{next_idx_d, 3'b000} +: 8]);
    in_word_d   = mx_decode(in_scale, in_elements[7:0]);
`ifdef MXINT8_DEQUANT_PREFETCH_EN
    buf_word_d  = mx_decode(buf_scale_q, buf_q[7:0]);
`endif
  end

  // Block capture, stream sequencing and registered output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      blk_q       <= {BLK_W{1'b0}};
      scale_q     <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_index_q <= 5'd0;
      out_last_q  <= 1'b0;
`ifdef MXINT8_DEQUANT_PREFETCH_EN
      buf_q       <= {BLK_W{1'b0}};
      buf_scale_q <= 8'd0;
      buf_full_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            blk_q       <= in_elements;
            scale_q     <= in_scale;
            out_data_q  <= in_word_d;
            out_index_q <= 5'd0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (last_hs_s) begin
`ifdef MXINT8_DEQUANT_PREFETCH_EN
            if (buf_full_q) begin
              blk_q       <= buf_q;
              scale_q     <= buf_scale_q;
              out_data_q  <= buf_word_d;
              out_index_q <= 5'd0;
              out_last_q  <= 1'b0;
              buf_full_q  <= 1'b0;
            end else if (accept_s) begin
              // Buffer empty but a block arrives on the final handshake: chain it straight in.
              blk_q       <= in_elements;
              scale_q     <= in_scale;
              out_data_q  <= in_word_d;
              out_index_q <= 5'd0;
              out_last_q  <= 1'b0;
            end else begin
              out_valid_q <= 1'b0;
              out_index_q <= 5'd0;
              out_last_q  <= 1'b0;
              state_q     <= S_IDLE;
            end
`else
            out_valid_q <= 1'b0;
            out_index_q <= 5'd0;
            out_last_q  <= 1'b0;
            state_q     <= S_IDLE;
`endif
          end else if (out_hs_s) begin
            out_data_q  <= next_word_d;
            out_index_q <= next_idx_d;
            out_last_q  <= (next_idx_d == 5'd31);
          end
`ifdef MXINT8_DEQUANT_PREFETCH_EN
          if (accept_s && !last_hs_s) begin
            buf_q       <= in_elements;
            buf_scale_q <= in_scale;
            buf_full_q  <= 1'b1;
          end
`endif
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_mxint8_dequant_stream.sv
// Directed bench for mxint8_dequant_stream with hand-computed binary32 expectations.
module tb_mxint8_dequant_stream;

`ifdef MXINT8_DEQUANT_PREFETCH_EN
  localparam int EXP_GAP = 0;
`else
  localparam int EXP_GAP = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_scale;
  logic [255:0] in_elements;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [4:0]   out_index;
  logic         out_last;

  int           checks_cnt = 0;
  int           fail_cnt   = 0;
  logic [31:0]  exp_q [32];
  logic [255:0] blk_s;

  mxint8_dequant_stream dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_scale    (in_scale),
    .in_elements (in_elements),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic fill_block(input logic [7:0] v, input logic [31:0] w);
    for (int i = 0; i < 32; i++) begin
      blk_s[8*i +: 8] = v;
      exp_q[i]        = w;
    end
  endtask

  task automatic set_elem(input int i, input logic [7:0] v, input logic [31:0] w);
    blk_s[8*i +: 8] = v;
    exp_q[i]        = w;
  endtask

  // Offer blk_s until accepted (bounded), then scramble the inputs so late sampling shows up.
  task automatic offer(input string tag, input logic [7:0] s);
    logic acc;
    logic rdy;
    acc         = 1'b0;
    in_scale    = s;
    in_elements = blk_s;
    in_valid    = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      acc = rdy;
    end
    in_valid    = 1'b0;
    in_scale    = 8'hFF;
    in_elements = {256{1'b1}};
    chk({tag, "_accept"}, 32'(acc), 32'd1);
  endtask

  // Walk all 32 outputs against exp_q, optionally stalling at one index.
  task automatic drain(input string tag, input int stall_at, input int stall_len);
    for (int i = 0; i < 32; i++) begin
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_idx"},   32'(out_index), i);
      chk({tag, "_data"},  out_data, exp_q[i]);
      chk({tag, "_last"},  32'(out_last), 32'(i == 31));
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          @(posedge clk); #1;
          chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
          chk({tag, "_hold_idx"},   32'(out_index), i);
          chk({tag, "_hold_data"},  out_data, exp_q[i]);
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_end_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   seen;
    int   gap;
    logic rdy;
    logic b_acc;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_scale    = 8'd0;
    in_elements = 256'd0;
    out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready),  32'd0);
    chk("rst_valid",    32'(out_valid), 32'd0);
    chk("rst_idx",      32'(out_index), 32'd0);
    chk("rst_last",     32'(out_last),  32'd0);
    chk("rst_data",     out_data,       32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // scale 127, all 1.0
    fill_block(8'h40, 32'h3F80_0000);
    offer("ones", 8'd127);
    drain("ones", -1, 0);

    // mixed signs, smallest and largest magnitudes at scale 127
    fill_block(8'h40, 32'h3F80_0000);
    set_elem(0, 8'hC0, 32'hBF80_0000);
    set_elem(1, 8'h01, 32'h3C80_0000);
    set_elem(2, 8'h00, 32'h0000_0000);
    set_elem(3, 8'h7F, 32'h3FFE_0000);
    offer("mix127", 8'd127);
    drain("mix127", -1, 0);

    // top of the exponent range, including overflow to -inf
    fill_block(8'h00, 32'h0000_0000);
    set_elem(0, 8'h7F, 32'h7F7E_0000);
    set_elem(1, 8'h80, 32'hFF80_0000);
    set_elem(2, 8'hFF, 32'hFC00_0000);
    offer("s254", 8'd254);
    drain("s254", -1, 0);

    // scale 0: subnormals and the smallest normal
    fill_block(8'h00, 32'h0000_0000);
    set_elem(0, 8'h01, 32'h0001_0000);
    set_elem(1, 8'h40, 32'h0040_0000);
    set_elem(2, 8'h80, 32'h8080_0000);
    set_elem(3, 8'hFF, 32'h8001_0000);
    offer("s0", 8'd0);
    drain("s0", -1, 0);

    // scale 6: subnormal/normal boundary
    fill_block(8'h00, 32'h0000_0000);
    set_elem(0, 8'h01, 32'h0040_0000);
    set_elem(1, 8'h02, 32'h0080_0000);
    set_elem(2, 8'h81, 32'h837E_0000);
    offer("s6", 8'd6);
    drain("s6", -1, 0);

    // NaN scale overrides every element
    fill_block(8'h40, 32'h7FC0_0000);
    set_elem(1, 8'h00, 32'h7FC0_0000);
    set_elem(2, 8'h80, 32'h7FC0_0000);
    set_elem(3, 8'h7F, 32'h7FC0_0000);
    offer("nan", 8'hFF);
    drain("nan", -1, 0);

    // backpressure at index 5
    fill_block(8'h40, 32'h3F80_0000);
    set_elem(5, 8'h06, 32'h3DC0_0000);
    set_elem(6, 8'h07, 32'h3DE0_0000);
    offer("stall", 8'd127);
    drain("stall", 5, 3);

    // reset while index 10 is presented
    fill_block(8'h40, 32'h3F80_0000);
    offer("mrst", 8'd127);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("mrst_idx10", 32'(out_index), 32'd10);
    rst_n = 1'b0;
    #1;
    chk("mrst_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_idx",   32'(out_index), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mrst_ready_high", 32'(in_ready), 32'd1);
    fill_block(8'hC0, 32'hBF80_0000);
    offer("after_rst", 8'd127);
    drain("after_rst", -1, 0);

    // two blocks back to back
    fill_block(8'h40, 32'h3F80_0000);
    offer("b2b_a", 8'd127);
    fill_block(8'hC0, 32'hBF80_0000);
    in_scale    = 8'd127;
    in_elements = blk_s;
    in_valid    = 1'b1;
    seen  = 0;
    gap   = 0;
    b_acc = 1'b0;
    for (int cyc = 0; cyc < 100 && seen < 64; cyc++) begin
      rdy = in_ready;
      if (out_valid) begin
        chk("b2b_idx",  32'(out_index), seen % 32);
        chk("b2b_data", out_data, (seen < 32) ? 32'h3F80_0000 : 32'hBF80_0000);
        seen++;
      end else begin
        gap++;
      end
      @(posedge clk); #1;
      if (in_valid && rdy) begin
        in_valid    = 1'b0;
        in_elements = {256{1'b1}};
        b_acc       = 1'b1;
      end
    end
    chk("b2b_count",  seen, 32'd64);
    chk("b2b_gap",    gap, EXP_GAP);
    chk("b2b_accept", 32'(b_acc), 32'd1);
    chk("b2b_end",    32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
